// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_seq : multi-cycle unsigned ALU, serial operand load, two-beat result  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op_codes,
    input  logic             valid,
    output logic [WIDTH-1:0] o,
    output logic             ready,
    output logic             last,
    output logic             busy,
    output logic             err
);

    localparam int ACC_W = 2 * WIDTH + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_B = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_OUT_LO = 3'd3;
    localparam logic [2:0] S_OUT_HI = 3'd4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             err_q, err_d;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_mul_upper;
    logic [ACC_W-1:0] w_mul_step;
    logic [ACC_W-1:0] w_div_shift;
    logic [WIDTH:0]   w_div_rem;
    logic [WIDTH:0]   w_div_sub;
    logic [ACC_W-1:0] w_div_step;
    logic [ACC_W-1:0] w_step;
    logic             w_last_iter;

    assign w_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign w_diff = {1'b0, a_q} - {1'b0, b_q};

    // Shift-add: acc = {partial product, remaining multiplier bits}, LSB first.
    assign w_mul_upper = acc_q[ACC_W-1:WIDTH] + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign w_mul_step  = {1'b0, w_mul_upper, acc_q[WIDTH-1:1]};

    // Restoring division: acc = {remainder, dividend bits / quotient bits}.
    assign w_div_shift = {acc_q[ACC_W-2:0], 1'b0};
    assign w_div_rem   = w_div_shift[ACC_W-1:WIDTH];
    assign w_div_sub   = w_div_rem - {1'b0, b_q};
    assign w_div_step  = (w_div_rem >= {1'b0, b_q})
                       ? {w_div_sub, w_div_shift[WIDTH-1:1], 1'b1}
                       : {w_div_rem, w_div_shift[WIDTH-1:1], 1'b0};

    assign w_step      = (op_q == OP_DIV) ? w_div_step : w_mul_step;
    assign w_last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        o_d     = o_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    a_d     = in;
                    op_d    = op_codes;
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (valid) begin
                    b_d     = in;
                    cnt_d   = '0;
                    acc_d   = {{(WIDTH+1){1'b0}}, (op_q == OP_DIV) ? a_q : in};
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!op_q[1]) begin
                    o_d     = (op_q == OP_ADD) ? w_sum[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    hi_d    = {{(WIDTH-1){1'b0}}, (op_q == OP_ADD) ? w_sum[WIDTH] : w_diff[WIDTH]};
                    err_d   = 1'b0;
                    state_d = S_OUT_LO;
                end else begin
                    acc_d = w_step;
                    if (w_last_iter) begin
                        o_d     = w_step[WIDTH-1:0];
                        hi_d    = w_step[2*WIDTH-1:WIDTH];
                        err_d   = (op_q == OP_DIV) && (b_q == '0);
                        state_d = S_OUT_LO;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_OUT_LO: begin
                o_d     = hi_q;
                state_d = S_OUT_HI;
            end
            S_OUT_HI: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            o_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            o_q     <= o_d;
            err_q   <= err_d;
        end
    end

    assign o     = o_q;
    assign ready = (state_q == S_OUT_LO) || (state_q == S_OUT_HI);
    assign last  = (state_q == S_OUT_HI);
    assign busy  = (state_q != S_IDLE);
    assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for alu_seq: 8- and 16-bit instances checked cycle by cycle against an arithmetic model.
module tb_alu_seq;

    typedef struct {
        int                due;
        longint unsigned   lo;
        longint unsigned   hi;
        bit                e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [1:0]  opc;
    logic        vld;
    int          sel;

    logic [7:0]  o8;
    logic        ready8, last8, busy8, err8;
    logic [15:0] o16;
    logic        ready16, last16, busy16, err16;
    logic        valid8, valid16;

    int              cyc = 0;
    int              n_cmp = 0;
    int              n_bad = 0;
    bit              chk_en = 1'b0;
    bit              txn_open = 1'b0;
    longint unsigned last_o [2];
    exp_t            q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign valid8  = vld && (sel == 0);
    assign valid16 = vld && (sel == 1);

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in(din[7:0]), .op_codes(opc), .valid(valid8),
        .o(o8), .ready(ready8), .last(last8), .busy(busy8), .err(err8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in(din[15:0]), .op_codes(opc), .valid(valid16),
        .o(o16), .ready(ready16), .last(last16), .busy(busy16), .err(err16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic void model(input int s, input logic [1:0] op,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned lo, output longint unsigned hi,
                                  output bit e);
        int              w;
        longint unsigned mask;
        longint unsigned r;
        w    = (s == 1) ? 16 : 8;
        mask = (64'd1 << w) - 1;
        e    = 1'b0;
        case (op)
            2'b00: begin r = a + b; lo = r & mask; hi = r >> w; end
            2'b01: begin lo = (a - b) & mask; hi = (a < b) ? 1 : 0; end
            2'b10: begin r = a * b; lo = r & mask; hi = r >> w; end
            default: begin
                if (b == 0) begin lo = mask; hi = a; e = 1'b1; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    task automatic pin(input string name, input int s, input logic [1:0] op,
                       input longint unsigned a, input longint unsigned b,
                       input longint unsigned lo_r, input longint unsigned hi_r, input bit e_r);
        longint unsigned lo, hi;
        bit              e;
        model(s, op, a, b, lo, hi, e);
        check({name, "_lo"}, lo, lo_r);
        check({name, "_hi"}, hi, hi_r);
        check({name, "_err"}, 64'(e), 64'(e_r));
    endtask

    // Caller is at a falling edge; A is accepted after `pre` ignored rising edges.
    task automatic run_op(input logic [1:0] op, input longint unsigned a, input longint unsigned b,
                          input int pre, input int gap);
        exp_t e;
        int   w;
        w   = (sel == 1) ? 16 : 8;
        vld = 1'b1;
        din = 32'(a);
        opc = op;
        repeat (pre) begin @(posedge clk); @(negedge clk); end
        @(posedge clk);
        @(negedge clk);
        txn_open = 1'b1;
        din = 32'(b);
        opc = ~op;
        if (gap > 0) begin
            vld = 1'b0;
            repeat (gap) begin @(posedge clk); @(negedge clk); end
            vld = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        din = 32'hA5A5_A5A5;
        model(sel, op, a, b, e.lo, e.hi, e.e);
        e.due = cyc + ((op[1] == 1'b0) ? 1 : w);
        q.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (txn_open && n < 64) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (txn_open) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout at cycle %0d: got busy after %0d cycles, expected completion", cyc, n);
            q.delete();
            txn_open = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_o8"}, 64'(o8), 0);
        check({tag, "_ready8"}, 64'(ready8), 0);
        check({tag, "_last8"}, 64'(last8), 0);
        check({tag, "_busy8"}, 64'(busy8), 0);
        check({tag, "_err8"}, 64'(err8), 0);
        check({tag, "_o16"}, 64'(o16), 0);
        check({tag, "_ready16"}, 64'(ready16), 0);
        check({tag, "_busy16"}, 64'(busy16), 0);
        check({tag, "_err16"}, 64'(err16), 0);
    endtask

    always begin
        logic [63:0] ro;
        logic        rr, rl, rb, re, other_r;
        @(negedge clk);
        #1;
        if (chk_en) begin
            if (sel == 1) begin
                ro = 64'(o16); rr = ready16; rl = last16; rb = busy16; re = err16; other_r = ready8;
            end else begin
                ro = 64'(o8); rr = ready8; rl = last8; rb = busy8; re = err8; other_r = ready16;
            end
            check("idle_dut_ready", 64'(other_r), 0);
            if (q.size() > 0 && cyc == q[0].due) begin
                check("lo_ready", 64'(rr), 1);
                check("lo_last", 64'(rl), 0);
                check("lo_data", ro, q[0].lo);
                check("lo_err", 64'(re), 64'(q[0].e));
                check("lo_busy", 64'(rb), 1);
                last_o[sel] = q[0].lo;
            end else if (q.size() > 0 && cyc == q[0].due + 1) begin
                check("hi_ready", 64'(rr), 1);
                check("hi_last", 64'(rl), 1);
                check("hi_data", ro, q[0].hi);
                check("hi_err", 64'(re), 64'(q[0].e));
                check("hi_busy", 64'(rb), 1);
                last_o[sel] = q[0].hi;
                void'(q.pop_front());
                txn_open = 1'b0;
            end else begin
                check("ready_low", 64'(rr), 0);
                check("last_low", 64'(rl), 0);
                check("o_hold", ro, last_o[sel]);
                check("busy", 64'(rb), 64'(txn_open));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d;
        rst = 1'b0;
        vld = 1'b0;
        din = '0;
        opc = 2'b00;
        sel = 0;
        last_o[0] = 0;
        last_o[1] = 0;

        pin("m_add", 0, 2'b00, 200, 100, 44, 1, 0);
        pin("m_sub_b", 0, 2'b01, 5, 10, 251, 1, 0);
        pin("m_sub", 0, 2'b01, 10, 5, 5, 0, 0);
        pin("m_mul", 0, 2'b10, 200, 3, 88, 2, 0);
        pin("m_div", 0, 2'b11, 15, 4, 3, 3, 0);
        pin("m_div0", 0, 2'b11, 15, 0, 255, 15, 1);
        pin("m_mul16", 1, 2'b10, 65535, 65535, 1, 65534, 0);
        pin("m_div16", 1, 2'b11, 1000, 7, 142, 6, 0);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        run_op(2'b00, 200, 100, 0, 0);   wait_done();
        run_op(2'b01, 5, 10, 0, 0);      wait_done();
        run_op(2'b01, 10, 5, 0, 3);      wait_done();
        run_op(2'b00, 255, 255, 0, 0);   wait_done();

        // Operand-looking pulses while executing must not disturb the product.
        run_op(2'b10, 200, 3, 0, 0);
        @(negedge clk); vld = 1'b1; din = 32'hFF; opc = 2'b00;
        @(negedge clk); vld = 1'b0;
        @(negedge clk); vld = 1'b1; din = 32'h11; opc = 2'b11;
        @(negedge clk); vld = 1'b0;
        wait_done();

        run_op(2'b10, 255, 255, 0, 0);   wait_done();
        run_op(2'b11, 15, 4, 0, 0);      wait_done();
        run_op(2'b11, 15, 0, 0, 0);      wait_done();
        run_op(2'b11, 7, 9, 0, 0);       wait_done();

        // Asynchronous reset in the fourth execute cycle of a multiply.
        run_op(2'b10, 200, 3, 0, 0);
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        #1 rst = 1'b0;
        #1.5 check_all_zero("async_rst");
        #1.5 rst = 1'b1;
        q.delete();
        txn_open = 1'b0;
        last_o[0] = 0;
        last_o[1] = 0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (10) @(negedge clk);
        run_op(2'b00, 1, 1, 0, 0);       wait_done();

        sel = 1;
        run_op(2'b10, 65535, 65535, 0, 0);
        d = q[0].due;
        while (cyc < d + 1) @(negedge clk);
        run_op(2'b11, 1000, 7, 1, 0);
        wait_done();

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised multi-cycle integer ALU; successor to the 8-bit ADD/SUB/MUL/DIV unit.
- Operands A and B are loaded serially over the shared `in` bus using a valid handshake.
- Executes add/sub in one cycle; unsigned multiply (shift-add) and divide (restoring) in WIDTH cycles each.
- Returns a double-width result as two `ready` beats (low, then high). Sits between the control sequencer and the result register file.

Parameters:
- WIDTH, 8, operand and output bus width in bits (legal range 4..32).
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in  input  WIDTH  operand bus; carries A on the first accepted beat, B on the second.
- op_codes  input  2  operation select: 00 ADD, 01 SUB, 10 MUL, 11 DIV; sampled with operand A only.
- valid  input  1  operand beat qualifier.
- o  output  WIDTH  result beat data.
- ready  output  1  result beat valid.
- last  output  1  high on the second (high-half) result beat.
- busy  output  1  high whenever state is not IDLE.
- err  output  1  divide-by-zero flag; valid on both result beats.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; o=0, ready=0, last=0, busy=0, err=0; counter and internal registers cleared. Applies at any time, including mid-operation; the operation in flight is discarded with no result beats.
- States: IDLE, LOAD_B, EXEC, OUT_LO, OUT_HI.
- IDLE: on valid=1, capture A=in and op=op_codes, then go to LOAD_B.
- LOAD_B: on valid=1, capture B=in, then go to EXEC. Without valid, stay in LOAD_B indefinitely.
- op_codes is ignored outside the A beat.
- EXEC, ADD/SUB: one cycle, then OUT_LO.
  - ADD: lo = (A+B) mod 2^WIDTH; hi = carry-out zero-extended.
  - SUB: lo = (A-B) mod 2^WIDTH; hi = borrow (1 when A<B) zero-extended.
- EXEC, MUL: exactly WIDTH cycles, one partial product per cycle, LSB of B first. Result is the unsigned 2*WIDTH product; lo = low half, hi = high half.
- EXEC, DIV: exactly WIDTH cycles of restoring division. lo = quotient, hi = remainder.
- DIV with B=0: still takes WIDTH cycles; lo = all ones, hi = A, err=1. err=0 for every other case.
- Latency: with B captured on edge k, the first result beat (OUT_LO) is visible after edge k+1 for ADD/SUB and after edge k+WIDTH for MUL/DIV.
- OUT_LO: one cycle with ready=1, last=0, o=lo.
- OUT_HI: next cycle with ready=1, last=1, o=hi; then IDLE.
- No downstream back-pressure: beats are never stalled.
- Outside OUT_LO/OUT_HI: ready=0 and last=0; o holds its last driven value.
- busy=1 in LOAD_B, EXEC, OUT_LO and OUT_HI.
- valid is ignored in EXEC, OUT_LO and OUT_HI; it does not queue.
- A new A beat is accepted in the first IDLE cycle after OUT_HI, so back-to-back operations are possible.
- All arithmetic is unsigned. Internal accumulators are 2*WIDTH+1 bits, so nothing truncates before output.
- The counter runs 0..WIDTH-1 and resets to 0 on entry to EXEC.

Test Plan:
- WIDTH=8, ADD, A=200, B=100 -> beats o=44 (last=0) then o=1 (last=1); first beat one cycle after B captured; err=0.
- WIDTH=8, SUB, A=5, B=10 -> o=251 then o=1 (borrow); SUB A=10, B=5 -> o=5 then o=0.
- WIDTH=8, MUL, A=200, B=3 -> o=88 then o=2 (600); first beat exactly 8 cycles after B captured; valid pulses during EXEC are ignored and do not change the result.
- WIDTH=8, DIV: A=15, B=4 -> o=3 then o=3, err=0. A=15, B=0 -> o=255 then o=15, err=1 on both beats.
- WIDTH=8, reset mid-MUL: drop rst to 0 at EXEC cycle 4 for 3 ns asynchronously -> outputs 0 immediately, no ready pulse; next ADD 1+1 -> o=2 then o=0.
- WIDTH=16: MUL A=65535, B=65535 -> o=1 then o=65534; first beat 16 cycles after B captured. Back-to-back DIV 1000/7 -> o=142 then o=6, A beat accepted in the first IDLE cycle.
